// File: rtl/pulp_cluster_dma_pkg.sv
// Shared constants for the pulp_cluster DMA load/store stages.
package pulp_cluster_dma_pkg;

  localparam int DATA_W_DEF = 32;

  // FSM encoding, kept as plain constants so legacy tools can read it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // DMA beat size code for 32-bit words.
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/pulp_dma_out_reg.sv
// Single-entry valid/ready pipeline register carrying a last flag.
// A new beat may be loaded in the same cycle the held one is consumed.
module pulp_dma_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_load_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // Load wins over drain; last is only ever high alongside valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_load_i) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      last_q  <= in_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/pulp_cluster_dma_load_ctrl.sv
// DMA read-side load stage: splits a word range into bursts of at most
// CHUNK_WORDS, issues read requests, and forwards beats downstream.
module pulp_cluster_dma_load_ctrl
  import pulp_cluster_dma_pkg::*;
#(
  parameter int CHUNK_WORDS = 64,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_done,
  input  logic [31:0]       conf_info_base,
  input  logic [31:0]       conf_info_len,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_chnl_valid,
  output logic              dma_read_chnl_ready,
  input  logic [DATA_W-1:0] dma_read_chnl_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              load_done,
  output logic              busy
);

  localparam logic [31:0] CHUNK = 32'(CHUNK_WORDS);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] beats_q, beats_d;
  logic        load_done_q;

  logic [31:0] chunk;
  logic        req_hs, beat_acc, beat_last;

  assign chunk     = (rem_q < CHUNK) ? rem_q : CHUNK;
  assign req_hs    = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign beat_acc  = dma_read_chnl_valid && dma_read_chnl_ready;
  assign beat_last = (beats_q == 32'd1) && (rem_q == 32'd0);

  assign dma_read_ctrl_valid       = (state_q == ST_REQ);
  assign dma_read_ctrl_data_index  = (state_q == ST_REQ) ? addr_q : '0;
  assign dma_read_ctrl_data_length = (state_q == ST_REQ) ? chunk  : '0;
  assign dma_read_ctrl_data_size   = SIZE_WORD;
  assign dma_read_chnl_ready       = (state_q == ST_XFER) && (!out_valid || out_ready);
  assign busy                      = (state_q != ST_IDLE);
  assign load_done                 = load_done_q;

  // Next-state and counter updates for the burst-splitting FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (conf_done) begin
          addr_d  = conf_info_base;
          rem_d   = conf_info_len;
          state_d = (conf_info_len == 32'd0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_hs) begin
          addr_d  = addr_q + chunk;
          rem_d   = rem_q - chunk;
          beats_d = chunk;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_acc) begin
          beats_d = beats_q - 32'd1;
          if (beats_q == 32'd1) state_d = (rem_q == 32'd0) ? ST_DRAIN : ST_REQ;
        end
      end
      // Leave as soon as the final word is being consumed this cycle.
      ST_DRAIN: if (!out_valid || out_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; the done pulse is registered off DONE,
  // so it lands two cycles after the last downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      load_done_q <= (state_q == ST_DONE);
    end
  end

  pulp_dma_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_load_i   (beat_acc),
    .in_data_i   (dma_read_chnl_data),
    .in_last_i   (beat_last),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

endmodule
